// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared QPSK symbol width, default amplitude and bit-to-level mapping
package qpsk_pkg;

    localparam int SYM_W = 16;
    localparam logic signed [SYM_W-1:0] AMP_DEFAULT = 16'sd8191;

    // Bit 0 maps to +amp, bit 1 to -amp; negation stays at SYM_W signed width.
    function automatic logic signed [SYM_W-1:0] map_bit(
        input logic                    b,
        input logic signed [SYM_W-1:0] amp
    );
        return b ? -amp : amp;
    endfunction

endpackage

// File: rtl/qpsk_bit_split_if.sv
// rtl/qpsk_bit_split_if.sv - symbol output bundle toward the modulator/NCO mixer
interface qpsk_bit_split_if #(
    parameter int FRAME_BITS = 40
);
    localparam int IW = $clog2(FRAME_BITS / 2);

    logic signed [qpsk_pkg::SYM_W-1:0] i_o;
    logic signed [qpsk_pkg::SYM_W-1:0] q_o;
    logic                              sym_vld;
    logic [IW-1:0]                     sym_idx;
    logic                              frame_sof;

    modport master (output i_o, q_o, sym_vld, sym_idx, frame_sof);
    modport slave  (input  i_o, q_o, sym_vld, sym_idx, frame_sof);

endinterface

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit period counter with mid-bit and end-bit strobes
module bit_timer #(
    parameter int DIV = 12500
) (
    input  logic clk,
    input  logic rst,
    output logic mid,
    output logic last
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign mid  = (cnt == CW'(DIV / 2));
    assign last = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/qpsk_bit_split.sv
// rtl/qpsk_bit_split.sv - pairs serial frame bits into dibits and drives held I/Q levels
module qpsk_bit_split
    import qpsk_pkg::*;
#(
    parameter int                    DIV        = 12500,
    parameter int                    FRAME_BITS = 40,
    parameter logic signed [SYM_W-1:0] AMP      = AMP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_i,
    qpsk_bit_split_if.master sym
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int IW = $clog2(FRAME_BITS / 2);

    logic          mid;
    logic          last;
    logic [BW-1:0] bit_idx;
    logic          i_bit;
    logic          q_bit;

    bit_timer #(.DIV(DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .mid  (mid),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx       <= '0;
            i_bit         <= 1'b0;
            q_bit         <= 1'b0;
            sym.i_o       <= '0;
            sym.q_o       <= '0;
            sym.sym_vld   <= 1'b0;
            sym.sym_idx   <= '0;
            sym.frame_sof <= 1'b0;
        end else begin
            sym.sym_vld   <= 1'b0;
            sym.frame_sof <= 1'b0;

            if (mid) begin
                if (bit_idx[0]) begin
                    q_bit <= ser_i;
                end else begin
                    i_bit <= ser_i;
                end
            end

            if (last) begin
                bit_idx <= (bit_idx == BW'(FRAME_BITS - 1)) ? '0 : bit_idx + 1'b1;
                // The odd bit closes a dibit; both halves are already captured.
                if (bit_idx[0]) begin
                    sym.i_o       <= map_bit(i_bit, AMP);
                    sym.q_o       <= map_bit(q_bit, AMP);
                    sym.sym_idx   <= IW'(bit_idx >> 1);
                    sym.sym_vld   <= 1'b1;
                    sym.frame_sof <= (bit_idx == BW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_qpsk_bit_split.sv
// tb/tb_qpsk_bit_split.sv - self-checking bench for qpsk_bit_split
module tb_qpsk_bit_split;

    localparam int DIV  = 4;
    localparam int FB   = 40;
    localparam int AINT = 8191;
    localparam logic signed [15:0] A = 16'sd8191;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_i = 1'b0;

    always #5 clk = ~clk;

    qpsk_bit_split_if #(.FRAME_BITS(FB)) sif ();

    qpsk_bit_split #(.DIV(DIV), .FRAME_BITS(FB), .AMP(A)) dut (
        .clk   (clk),
        .rst   (rst),
        .ser_i (ser_i),
        .sym   (sif)
    );

    typedef struct {
        int   t;
        int   i;
        int   q;
        logic vld;
        int   idx;
        logic sof;
    } vec_t;

    vec_t tbl[$];
    logic stim[0:255];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lvl(input logic b);
        return b ? -AINT : AINT;
    endfunction

    function automatic vec_t mk(input int t, input int i, input int q,
                                input logic v, input int idx, input logic sof);
        vec_t e;
        e.t = t; e.i = i; e.q = q; e.vld = v; e.idx = idx; e.sof = sof;
        return e;
    endfunction

    // kind: 0 frame FF_17_18_19_FF, 1 all zero, 2 all one, 3 random bits
    task automatic run(input int kind, input bit glitch, input bit mid_rst, input int ncyc);
        logic [39:0] fr;
        bit   prev_rst;
        bit   rst_c;
        int   rel;
        int   first_rel;
        int   vld_cnt;
        int   t;
        int   n;
        int   ei, eq, eidx;
        logic ev, esof;
        fr = 40'hFF171819FF;
        for (int b = 0; b < 256; b++) begin
            case (kind)
                0:       stim[b] = fr[39 - (b % 40)];
                1:       stim[b] = 1'b0;
                2:       stim[b] = 1'b1;
                default: stim[b] = 1'($urandom);
            endcase
        end
        prev_rst  = 1'b1;
        rel       = 0;
        first_rel = -1;
        vld_cnt   = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c > 0) begin
                t = c - rel;
                if (prev_rst || t < 8) begin
                    ei = 0; eq = 0; ev = 1'b0; eidx = 0; esof = 1'b0;
                end else begin
                    n    = (t - 8) / 8;
                    ei   = lvl(stim[2 * n]);
                    eq   = lvl(stim[2 * n + 1]);
                    ev   = (t % 8 == 0);
                    eidx = n % (FB / 2);
                    esof = ev && (eidx == 0);
                end
                chk("i_o", int'(sif.i_o), ei);
                chk("q_o", int'(sif.q_o), eq);
                chk("sym_vld", int'(sif.sym_vld), int'(ev));
                chk("sym_idx", int'(sif.sym_idx), eidx);
                chk("frame_sof", int'(sif.frame_sof), int'(esof));

                if (kind == 0 && !glitch && !mid_rst && !prev_rst) begin
                    foreach (tbl[k]) begin
                        if (tbl[k].t == t) begin
                            chk($sformatf("tbl_i_t%0d", t), int'(sif.i_o), tbl[k].i);
                            chk($sformatf("tbl_q_t%0d", t), int'(sif.q_o), tbl[k].q);
                            chk($sformatf("tbl_vld_t%0d", t), int'(sif.sym_vld), int'(tbl[k].vld));
                            chk($sformatf("tbl_idx_t%0d", t), int'(sif.sym_idx), tbl[k].idx);
                            chk($sformatf("tbl_sof_t%0d", t), int'(sif.frame_sof), int'(tbl[k].sof));
                        end
                    end
                end
                if (kind == 0 && !mid_rst && !prev_rst && t >= 8 && t < 168 && sif.sym_vld)
                    vld_cnt++;
                if (mid_rst && !prev_rst && rel != first_rel && t == 8) begin
                    chk("rerelease_vld", int'(sif.sym_vld), 1);
                    chk("rerelease_sof", int'(sif.frame_sof), 1);
                    chk("rerelease_idx", int'(sif.sym_idx), 0);
                end
                if (mid_rst && prev_rst && first_rel >= 0)
                    chk("in_reset_i_o", int'(sif.i_o), 0);
            end

            rst_c = (c < 3) ||
                    (mid_rst && first_rel >= 0 && (c - first_rel) >= 50 && (c - first_rel) < 53);
            if (!rst_c && prev_rst) begin
                rel = c;
                if (first_rel < 0) first_rel = c;
            end
            rst   = rst_c;
            ser_i = rst_c ? 1'($urandom)
                          : (stim[(c - rel) / DIV] ^ (glitch && ((c - rel) % DIV == 0)));
            prev_rst = rst_c;
        end
        if (kind == 0 && !mid_rst)
            chk("sym_vld_per_frame", vld_cnt, 20);
    endtask

    initial begin
        tbl.push_back(mk(7,    0,     0,     1'b0, 0,  1'b0));
        tbl.push_back(mk(8,   -AINT, -AINT,  1'b1, 0,  1'b1));
        tbl.push_back(mk(9,   -AINT, -AINT,  1'b0, 0,  1'b0));
        tbl.push_back(mk(40,   AINT,  AINT,  1'b1, 4,  1'b0));
        tbl.push_back(mk(48,   AINT, -AINT,  1'b1, 5,  1'b0));
        tbl.push_back(mk(56,   AINT, -AINT,  1'b1, 6,  1'b0));
        tbl.push_back(mk(64,  -AINT, -AINT,  1'b1, 7,  1'b0));
        tbl.push_back(mk(160, -AINT, -AINT,  1'b1, 19, 1'b0));
        tbl.push_back(mk(167, -AINT, -AINT,  1'b0, 19, 1'b0));
        tbl.push_back(mk(168, -AINT, -AINT,  1'b1, 0,  1'b1));

        run(0, 1'b0, 1'b0, 400);
        run(0, 1'b1, 1'b0, 400);
        run(0, 1'b0, 1'b1, 200);
        run(1, 1'b0, 1'b0, 200);
        run(2, 1'b0, 1'b0, 200);
        run(3, 1'b0, 1'b0, 400);
        run(3, 1'b1, 1'b1, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
